// File: rtl/vram_pkg.sv
// Shared types and sizes for the video RAM arbiter.
// Owner tags and CPU sequencer states.
package vram_pkg;

  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 8;
  localparam int STALL_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_CPU
  } owner_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_ACK,
    S_HOLD
  } cpu_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has absolute priority,
// CPU accesses are sequenced with req/ack and a WAIT-style stall.
module vram_arbiter #(
  parameter int ADDR_W  = vram_pkg::ADDR_W,
  parameter int DATA_W  = vram_pkg::DATA_W,
  parameter int STALL_W = vram_pkg::STALL_W
) (
  input  logic              clk_pix,
  input  logic              nreset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [STALL_W-1:0] stall_cnt
);

  import vram_pkg::*;

  cpu_state_t state;
  cpu_state_t state_nx;
  owner_t     owner_q;
  owner_t     owner_nx;
  logic       cpu_go;
  logic       stall_inc;

  // Issue cycle: pick the single requester that drives the RAM
  always_comb begin
    cpu_go    = 1'b0;
    owner_nx  = OWN_NONE;
    ram_addr  = vid_addr;
    ram_we    = 1'b0;
    ram_wdata = cpu_wdata;
    unique case (1'b1)
      vid_req: begin
        owner_nx = OWN_VID;
      end
      (!vid_req && cpu_req && state == S_IDLE): begin
        cpu_go   = 1'b1;
        ram_addr = cpu_addr;
        ram_we   = cpu_we & nreset;
        owner_nx = cpu_we ? OWN_NONE : OWN_CPU;
      end
      default: begin
      end
    endcase
  end

  // CPU sequencer next state and stall detection
  always_comb begin
    state_nx  = state;
    stall_inc = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cpu_go) begin
          state_nx = cpu_we ? S_ACK : S_READ;
        end else if (cpu_req && vid_req) begin
          stall_inc = 1'b1;
        end
      end
      S_READ: state_nx = S_ACK;
      S_ACK:  state_nx = S_HOLD;
      S_HOLD: begin
        if (!cpu_req) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the sequencer state
  always_comb begin
    cpu_ack    = (state == S_ACK);
    cpu_wait_n = !(cpu_req &&
                   (state == S_IDLE || state == S_READ));
  end

  // Sequencer state and owner tag of the read in flight
  always_ff @(posedge clk_pix) begin
    if (!nreset) begin
      state   <= S_IDLE;
      owner_q <= OWN_NONE;
    end else begin
      state   <= state_nx;
      owner_q <= owner_nx;
    end
  end

  // Route returning RAM data to the video side by owner tag
  always_ff @(posedge clk_pix) begin
    if (!nreset) begin
      vid_data  <= '0;
      vid_valid <= 1'b0;
    end else begin
      vid_valid <= (owner_q == OWN_VID);
      if (owner_q == OWN_VID) begin
        vid_data <= ram_rdata;
      end
    end
  end

  // Capture CPU read data; held otherwise, writes leave it alone
  always_ff @(posedge clk_pix) begin
    if (!nreset) begin
      cpu_rdata <= '0;
    end else if (state == S_READ && owner_q == OWN_CPU) begin
      cpu_rdata <= ram_rdata;
    end
  end

  // Saturating count of cycles a CPU issue lost to video
  always_ff @(posedge clk_pix) begin
    if (!nreset) begin
      stall_cnt <= '0;
    end else if (stall_inc && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and randomized bench for the VRAM arbiter
// with a transaction-level reference model and RAM emulation.
module tb_vram_arbiter;

  import vram_pkg::*;

  logic               clk_pix = 1'b0;
  logic               nreset;
  logic               vid_req;
  logic [ADDR_W-1:0]  vid_addr;
  logic [DATA_W-1:0]  vid_data;
  logic               vid_valid;
  logic               cpu_req;
  logic               cpu_we;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [DATA_W-1:0]  cpu_wdata;
  logic [DATA_W-1:0]  cpu_rdata;
  logic               cpu_ack;
  logic               cpu_wait_n;
  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_we;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_rdata;
  logic [STALL_W-1:0] stall_cnt;

  logic [7:0] mem     [0:8191] = '{default: 8'h00};
  logic [7:0] ref_mem [0:8191] = '{default: 8'h00};

  typedef struct {
    int         due;
    logic [7:0] d;
  } vexp_t;

  vexp_t vq[$];

  int checks = 0;
  int errors = 0;

  int         gap;
  int         t0;
  int         ack_at;
  logic       busy;
  logic       issued;
  logic       go;
  logic       ack_e;
  logic       vv;
  logic [7:0] rd_e;
  logic [15:0] stall_exp;

  vram_arbiter dut (
    .clk_pix    (clk_pix),
    .nreset     (nreset),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .vid_valid  (vid_valid),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .cpu_wait_n (cpu_wait_n),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  // Synchronous single-port RAM, read-before-write
  always @(posedge clk_pix) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [12:0] a,
                           input logic [7:0] d);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    @(negedge clk_pix);
    chk("pre_we", 32'(ram_we), 32'(1));
    tick();
    @(negedge clk_pix);
    chk("pre_ack", 32'(cpu_ack), 32'(1));
    tick();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    ref_mem[a] = d;
    tick();
  endtask

  initial begin
    nreset    = 1'b0;
    vid_req   = 1'b0;
    vid_addr  = '0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = 8'hFF;

    // reset held with a pending CPU write
    repeat (3) tick();
    @(negedge clk_pix);
    chk("rst_ack", 32'(cpu_ack), 32'(0));
    chk("rst_vvalid", 32'(vid_valid), 32'(0));
    chk("rst_stall", 32'(stall_cnt), 32'(0));
    chk("rst_ramwe", 32'(ram_we), 32'(0));
    chk("rst_rdata", 32'(cpu_rdata), 32'(0));
    chk("rst_vdata", 32'(vid_data), 32'(0));
    nreset  = 1'b1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    tick();

    // idle write
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 13'h1800;
    cpu_wdata = 8'h47;
    @(negedge clk_pix);
    chk("wr_ramwe", 32'(ram_we), 32'(1));
    chk("wr_addr", 32'(ram_addr), 32'h1800);
    chk("wr_wdata", 32'(ram_wdata), 32'h47);
    chk("wr_waitn_t", 32'(cpu_wait_n), 32'(0));
    chk("wr_ack_t", 32'(cpu_ack), 32'(0));
    tick();
    @(negedge clk_pix);
    chk("wr_ack", 32'(cpu_ack), 32'(1));
    chk("wr_waitn_ack", 32'(cpu_wait_n), 32'(1));
    chk("wr_ramwe_ack", 32'(ram_we), 32'(0));
    tick();
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    ref_mem[13'h1800] = 8'h47;
    tick();
    chk("wr_mem", 32'(mem[13'h1800]), 32'h47);

    // read with request held afterwards
    cpu_write(13'h0000, 8'hA5);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 13'h0000;
    @(negedge clk_pix);
    chk("rd_waitn_t", 32'(cpu_wait_n), 32'(0));
    chk("rd_addr", 32'(ram_addr), 32'h0);
    tick();
    @(negedge clk_pix);
    chk("rd_ack_t1", 32'(cpu_ack), 32'(0));
    chk("rd_waitn_t1", 32'(cpu_wait_n), 32'(0));
    tick();
    @(negedge clk_pix);
    chk("rd_ack_t2", 32'(cpu_ack), 32'(1));
    chk("rd_data", 32'(cpu_rdata), 32'hA5);
    chk("rd_waitn_t2", 32'(cpu_wait_n), 32'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk_pix);
      chk("rd_hold_ack", 32'(cpu_ack), 32'(0));
      chk("rd_hold_waitn", 32'(cpu_wait_n), 32'(1));
    end
    tick();
    cpu_req = 1'b0;
    tick();

    // collision inside one 16-clock character period
    cpu_write(13'h0005, 8'h5C);
    cpu_write(13'h1000, 8'h10);
    cpu_write(13'h1001, 8'h20);
    for (int p = 0; p < 16; p++) begin
      vid_req  = (p == 10 || p == 12);
      vid_addr = (p == 12) ? 13'h1001 : 13'h1000;
      cpu_req  = (p >= 10 && p <= 13);
      cpu_we   = 1'b0;
      cpu_addr = 13'h0005;
      @(negedge clk_pix);
      if (p == 10) begin
        chk("col_addr10", 32'(ram_addr), 32'h1000);
        chk("col_waitn10", 32'(cpu_wait_n), 32'(0));
        chk("col_stall10", 32'(stall_cnt), 32'(0));
      end
      if (p == 11) begin
        chk("col_addr11", 32'(ram_addr), 32'h0005);
        chk("col_stall11", 32'(stall_cnt), 32'(1));
      end
      if (p == 12) begin
        chk("col_vv12", 32'(vid_valid), 32'(1));
        chk("col_vd12", 32'(vid_data), 32'h10);
        chk("col_ack12", 32'(cpu_ack), 32'(0));
      end
      if (p == 13) begin
        chk("col_ack13", 32'(cpu_ack), 32'(1));
        chk("col_rd13", 32'(cpu_rdata), 32'h5C);
        chk("col_vv13", 32'(vid_valid), 32'(0));
      end
      if (p == 14) begin
        chk("col_vv14", 32'(vid_valid), 32'(1));
        chk("col_vd14", 32'(vid_data), 32'h20);
        chk("col_stall14", 32'(stall_cnt), 32'(1));
      end
      tick();
    end

    // read followed by a fetch: data must not swap
    cpu_write(13'h0010, 8'h11);
    cpu_write(13'h1810, 8'h22);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 13'h0010;
    tick();
    vid_req  = 1'b1;
    vid_addr = 13'h1810;
    tick();
    vid_req = 1'b0;
    @(negedge clk_pix);
    chk("il_ack", 32'(cpu_ack), 32'(1));
    chk("il_rdata", 32'(cpu_rdata), 32'h11);
    chk("il_vv2", 32'(vid_valid), 32'(0));
    tick();
    cpu_req = 1'b0;
    @(negedge clk_pix);
    chk("il_vv3", 32'(vid_valid), 32'(1));
    chk("il_vdata", 32'(vid_data), 32'h22);
    chk("il_rdata3", 32'(cpu_rdata), 32'h11);
    tick();

    // reset during the READ cycle
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 13'h0000;
    tick();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    @(negedge clk_pix);
    chk("mr_ack", 32'(cpu_ack), 32'(0));
    chk("mr_rdata", 32'(cpu_rdata), 32'(0));
    chk("mr_waitn", 32'(cpu_wait_n), 32'(0));
    tick();
    @(negedge clk_pix);
    chk("mr_ack1", 32'(cpu_ack), 32'(0));
    tick();
    @(negedge clk_pix);
    chk("mr_ack2", 32'(cpu_ack), 32'(1));
    chk("mr_rdata2", 32'(cpu_rdata), 32'hA5);
    tick();
    cpu_req = 1'b0;
    tick();

    // stall counter saturation
    nreset = 1'b0;
    tick();
    nreset   = 1'b1;
    vid_req  = 1'b1;
    vid_addr = 13'h0000;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    repeat (65534) tick();
    @(negedge clk_pix);
    chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
    repeat (6) tick();
    @(negedge clk_pix);
    chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
    chk("sat_waitn", 32'(cpu_wait_n), 32'(0));
    vid_req = 1'b0;
    cpu_req = 1'b0;
    nreset  = 1'b0;
    tick();
    nreset = 1'b1;

    // randomized traffic against the transaction model
    busy      = 1'b0;
    issued    = 1'b0;
    gap       = 1;
    t0        = 0;
    ack_at    = 0;
    rd_e      = '0;
    stall_exp = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!busy) begin
        if (gap == 0) begin
          busy      = 1'b1;
          issued    = 1'b0;
          t0        = cyc;
          cpu_req   = 1'b1;
          cpu_we    = 1'($urandom_range(0, 1));
          cpu_addr  = 13'($urandom_range(0, 63));
          cpu_wdata = 8'($urandom);
        end else begin
          gap--;
          cpu_req = 1'b0;
        end
      end
      vid_req  = ($urandom_range(0, 3) == 0);
      vid_addr = 13'($urandom_range(0, 63));
      @(negedge clk_pix);
      chk("rnd_stall", 32'(stall_cnt), 32'(stall_exp));
      vv = (vq.size() > 0) && (vq[0].due == cyc);
      chk("rnd_vvalid", 32'(vid_valid), 32'(vv));
      if (vv) begin
        chk("rnd_vdata", 32'(vid_data), 32'(vq[0].d));
        void'(vq.pop_front());
      end
      if (vid_req) vq.push_back('{cyc + 2, ref_mem[vid_addr]});
      go    = 1'b0;
      ack_e = 1'b0;
      if (busy) begin
        if (!issued) begin
          if (vid_req) begin
            stall_exp++;
          end else begin
            go     = 1'b1;
            issued = 1'b1;
            ack_at = cyc + (cpu_we ? 1 : 2);
            rd_e   = ref_mem[cpu_addr];
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
          end
        end
        ack_e = issued && (cyc == ack_at);
      end
      chk("rnd_addr", 32'(ram_addr),
          32'(go ? cpu_addr : vid_addr));
      chk("rnd_we", 32'(ram_we), 32'(go && cpu_we));
      chk("rnd_ack", 32'(cpu_ack), 32'(ack_e));
      chk("rnd_waitn", 32'(cpu_wait_n),
          32'(!(busy && !ack_e)));
      if (ack_e && !cpu_we) begin
        chk("rnd_rdata", 32'(cpu_rdata), 32'(rd_e));
      end
      if (busy && (cyc - t0) > 200) begin
        chk("rnd_timeout", 32'(0), 32'(1));
        busy = 1'b0;
        gap  = 1;
      end
      if (ack_e) begin
        busy = 1'b0;
        gap  = $urandom_range(1, 3);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 8 KB video RAM (bitmap + attribute map) between the video fetch engine and the Z80 CPU bus.
- Video fetches have absolute priority and fixed latency: a request issued on fetch phase 10 returns data by phase 12 of each 16-clock character period.
- CPU reads and writes are sequenced with a request/acknowledge handshake and a WAIT-style stall output.
- Sits between the video module, the CPU memory decoder and the VRAM macro, all in the clk_pix domain.

Parameters:
ADDR_W, 13, VRAM address width (8 KB)
DATA_W, 8, VRAM data width
STALL_W, 16, width of saturating CPU stall counter

Ports:
clk_pix  in  1  pixel clock, 25.175 MHz; all logic rising-edge
nreset  in  1  synchronous active-low reset
vid_req  in  1  video fetch request, one-cycle pulse
vid_addr  in  ADDR_W  video fetch address, valid with vid_req
vid_data  out  DATA_W  registered fetch data
vid_valid  out  1  pulse, vid_data valid
cpu_req  in  1  CPU access request, level, held until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  registered read data, valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse
cpu_wait_n  out  1  low while cpu_req is pending and not yet acked
ram_addr  out  ADDR_W  VRAM address (combinational mux)
ram_we  out  1  VRAM write enable
ram_wdata  out  DATA_W  VRAM write data
ram_rdata  in  DATA_W  VRAM read data, 1-cycle synchronous latency
stall_cnt  out  STALL_W  count of cycles a CPU issue was blocked by video, saturating

Behaviour:
- Reset, sampled on the clk_pix edge with nreset=0, applies the following:
  - vid_data=0, vid_valid=0, cpu_rdata=0, cpu_ack=0, stall_cnt=0.
  - FSM=IDLE, owner pipeline cleared.
  - ram_we=0 during reset.
- Issue cycle t: exactly one requester drives the RAM.
  - vid_req=1 always wins: ram_addr=vid_addr, ram_we=0.
  - Otherwise, if FSM=IDLE and cpu_req=1: ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata.
  - Otherwise ram_we=0 and ram_addr=vid_addr.
- Owner tag: a 1-deep pipeline register records the owner of the cycle-t read (VID/CPU/NONE). ram_rdata at t+1 is routed by that tag.
- Video latency is fixed: vid_req at t gives vid_data registered at end of t+1, so vid_valid=1 in cycle t+2.
  - This holds regardless of CPU state. Video pulses on any cycles, including back-to-back, are each served.
- CPU FSM states:
  - IDLE:
    - cpu_req & !vid_req & we → ACK (write performed at t).
    - cpu_req & !vid_req & !we → READ.
    - cpu_req & vid_req → stay IDLE and stall_cnt++ (saturate at all-ones).
  - READ: capture ram_rdata into cpu_rdata → ACK. A vid_req in this cycle is served normally; no conflict, because ram_rdata belongs to cycle t.
  - ACK: cpu_ack=1 for exactly one cycle → HOLD.
  - HOLD: wait for cpu_req=0 → IDLE. This prevents a held request from being re-executed.
- Latency with no contention:
  - Write: issue t, ack t+1.
  - Read: issue t, ack t+2.
  - Each blocked cycle adds one.
- cpu_wait_n = !(cpu_req & FSM∈{IDLE,READ}). It rises in the ACK cycle.
- cpu_req dropping before ack (bus abort):
  - In IDLE: no access occurs.
  - In READ: the read completes and is acked; the FSM then goes to IDLE via HOLD.
- cpu_rdata holds its last value except on READ capture. Writes do not modify cpu_rdata.
- Reset mid-operation: any in-flight read is discarded, no ack is issued, and the owner tag is cleared. A write already in its issue cycle has been committed to RAM.
- Worst-case CPU wait is bounded because video issues ≤2 fetches per 16 clocks.

Decomposition:
- Package vram_pkg holds:
  - ADDR_W and DATA_W constants;
  - owner_t enum {OWN_NONE, OWN_VID, OWN_CPU};
  - cpu_state_t enum {S_IDLE, S_READ, S_ACK, S_HOLD}.
- Single module, no sub-module; the RAM macro stays external.

Test Plan:
- Reset: hold nreset=0 for 3 clocks with cpu_req=1 → cpu_ack=0, vid_valid=0, stall_cnt=0, ram_we=0.
- Idle CPU write: cpu_req=1, we=1, addr=0x1800, wdata=0x47 at t → ram_we=1, ram_addr=0x1800 at t; cpu_ack at t+1; cpu_wait_n low only at t.
- CPU read: RAM[0x0000]=0xA5, read at t → cpu_rdata=0xA5 and cpu_ack=1 at t+2; with cpu_req held 5 more cycles, no second RAM access occurs.
- Collision (16-clock phase loop, vid_req on phases 10 and 12): cpu read asserted at phase 10 → video owns phase 10, CPU issues at 11, vid_valid at 12 and 14, cpu_ack at 13, stall_cnt=1.
- Read/fetch interleave: CPU read of 0x0010 (=0x11) at t, vid_req 0x1810 (=0x22) at t+1 → cpu_rdata=0x11 at t+2, vid_data=0x22 at t+3, no swap.
- Reset mid-read: nreset=0 in the READ cycle → no cpu_ack; FSM=IDLE; a new read after reset completes in 2 cycles. Separately, force 65 540 collisions → stall_cnt saturates at 0xFFFF.
